moore_pattern_det: RTL and testbench
====================================

# moore_pattern_det

Parametrised Moore-type sequence detector and the general successor to the lab's fixed 2-bit-input Moore machines. It watches a stream of W-bit input symbols and asserts Z whenever the last LEN symbols equal a runtime-loadable pattern. Overlapping and non-overlapping detection modes are both supported, and a saturating match counter is provided. It sits between stimulus and sampling logic as a reusable FSM block, and its state is exported on Q for observation.

## Interface
- W, 2: symbol width in bits (≥1)
- LEN, 4: pattern length in symbols (1..16)
- CNT_W, 8: match counter width
- QW, derived: state width, clog2(LEN+1)
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset: one clock, synchronous, active-high
- EN  in  1  symbol-valid: X is consumed on an edge only when EN=1
- X  in  W  input symbol
- OVERLAP  in  1  1 = overlapping detection, 0 = non-overlapping
- LOAD  in  1  pattern write strobe
- PAT_IDX  in  clog2(LEN)  pattern slot to write
- PAT_DATA  in  W  symbol written to PAT[PAT_IDX]
- CLR  in  1  clears the match counter only
- Z  out  1  match flag, a decode of Q only (Moore)
- Q  out  QW  current state = number of pattern symbols currently matched
- MATCH_CNT  out  CNT_W  saturating count of matches
- CNT_SAT  out  1  high while MATCH_CNT is all ones

## Operation
- State Q=k (0..LEN) means the longest suffix of the consumed stream that equals PAT[0..k-1] has length k. Z = (Q==LEN).
- History: shift register of the last LEN symbols, with a per-entry valid bit. It advances only on edges with EN=1.
- Next state on an EN edge: the largest k in 1..LEN such that the k newest symbols (including X) are all valid and equal PAT[0..k-1]. If no such k exists, next state is 0. This gives KMP-equivalent fallback without a precomputed failure table.
- Non-overlap (OVERLAP=0) while Q==LEN: all history is treated as invalid before X is shifted in. Next Q is therefore (X==PAT[0]) ? 1 : 0 (that is, LEN when LEN=1).
- OVERLAP is sampled on every EN edge. A mode change takes effect on the next EN edge, with no flush.
- MATCH_CNT increments on the same edge where next Q == LEN and holds at all ones once saturated.
- Precedence per edge: RST > LOAD > EN. CLR acts independently and beats the increment on the same edge.
- LOAD edge: PAT[PAT_IDX] <= PAT_DATA, Q <= 0, all history invalidated, X ignored. An out-of-range PAT_IDX writes nothing but still performs the flush.
- EN=0 and no LOAD: Q, history and MATCH_CNT hold.

## Timing
- Reset values: Q=0, Z=0, MATCH_CNT=0, CNT_SAT=0, PAT[*]=0, all history invalid.
- Latency: Z rises in the cycle after the edge that consumes the final pattern symbol. MATCH_CNT updates on that same edge.
- Z, Q, MATCH_CNT and CNT_SAT are all registered or pure decodes of registers. There are no combinational paths from any input to any output.
- Back-to-back overlapping matches can hold Z high on consecutive cycles. Example: pattern all-A, continuous A input.
- RST mid-stream: the next cycle shows the full reset state, including the cleared pattern.
- Right after reset, the all-zero pattern matches an input of zeros once LEN valid symbols have been consumed.

## Structure
- Shared package moore_pkg holds:
  - the clog2 function;
  - default W/LEN/CNT_W constants;
  - the mode encodings OVERLAP_ON=1 / OVERLAP_OFF=0, shared by all lab Moore blocks.
- One natural sub-module, moore_prefix_cmp #(W,K):
  - compares the K newest history symbols plus their valid bits against PAT[0..K-1];
  - instantiated LEN times in a generate loop;
  - a priority encoder over its outputs selects next Q.

## Test plan
All scenarios use W=2, LEN=3, EN=1 unless noted.
- Overlap: PAT=1,2,1, OVERLAP=1, stream 1,2,1,2,1 -> Q=1,2,3,2,3; Z high after the 3rd and 5th symbols; MATCH_CNT=2.
- Non-overlap: same pattern and stream, OVERLAP=0 -> Q=1,2,3,0,1; Z high once; MATCH_CNT=1.
- Fallback: PAT=1,1,2, stream 1,1,1,2 -> Q=1,2,2,3; Z high only after the 4th symbol.
- Hold and counter: EN=0 for 5 cycles mid-pattern -> Q unchanged. With CNT_W=2, 4 matches -> MATCH_CNT=3, CNT_SAT=1. CLR together with a match edge -> MATCH_CNT=0.
- LOAD mid-stream: at Q=2, LOAD PAT_IDX=2 with PAT_DATA=3 -> Q=0 next cycle; then stream 1,2,3 -> Z=1.
- RST at Q=3 with Z=1 -> next cycle Q=0, Z=0, MATCH_CNT=0, PAT=0,0,0; stream 0,0,0 -> Z=1.

Source files
------------

// File: rtl/moore_pkg.sv
// Shared definitions for the lab's Moore sequence-detector blocks.
package moore_pkg;

  localparam int DEF_W     = 2;
  localparam int DEF_LEN   = 4;
  localparam int DEF_CNT_W = 8;

  // Detection-mode encoding on the OVERLAP pin, common to all lab Moore blocks.
  typedef enum logic {
    OVERLAP_OFF = 1'b0,
    OVERLAP_ON  = 1'b1
  } overlap_mode_e;

  // Ceiling log2 for elaboration-time width calculations; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/moore_prefix_cmp.sv
// Checks whether the K newest symbols of the window, all valid, spell PAT[0..K-1].
// Window slot 0 is the newest symbol; pattern slot j is PAT[j], so the newest
// symbol is compared against the last pattern symbol of the prefix.
module moore_prefix_cmp
  import moore_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = 1
) (
  input  logic [K*W-1:0] win_sym,
  input  logic [K-1:0]   win_vld,
  input  logic [K*W-1:0] pat_sym,
  output logic           hit
);

  logic [K-1:0] eq;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      assign eq[gi] = win_vld[gi] &&
                      (win_sym[gi*W +: W] == pat_sym[(K-1-gi)*W +: W]);
    end
  endgenerate

  assign hit = &eq;

endmodule

// File: rtl/moore_pattern_det.sv
// Moore sequence detector: Q counts how many leading pattern symbols the
// newest input suffix matches; Z decodes Q == LEN. The next state is found by
// testing every prefix length against the shifted history and keeping the
// longest hit, which gives KMP-style fallback without a failure table.
module moore_pattern_det
  import moore_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEN   = DEF_LEN,
  parameter int CNT_W = DEF_CNT_W,
  parameter int QW    = clog2(LEN + 1),
  parameter int IW    = (clog2(LEN) > 0) ? clog2(LEN) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [W-1:0]     X,
  input  logic             OVERLAP,
  input  logic             LOAD,
  input  logic [IW-1:0]    PAT_IDX,
  input  logic [W-1:0]     PAT_DATA,
  input  logic             CLR,
  output logic             Z,
  output logic [QW-1:0]    Q,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             CNT_SAT
);

  localparam logic [QW-1:0] Q_FULL = QW'(LEN);

  logic [QW-1:0]    q_q, q_d;
  logic [W-1:0]     hist_sym_q [LEN];
  logic [W-1:0]     hist_sym_d [LEN];
  logic             hist_vld_q [LEN];
  logic             hist_vld_d [LEN];
  logic [W-1:0]     pat_q [LEN];
  logic [W-1:0]     pat_d [LEN];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Window = history as it would look after consuming X (slot 0 newest).
  logic [LEN*W-1:0] win_sym;
  logic [LEN-1:0]   win_vld;
  logic [LEN*W-1:0] pat_flat;
  logic [LEN-1:0]   hit;
  logic [QW-1:0]    q_scan;
  logic             flush_hist;

  // After a complete match in non-overlap mode, older symbols may not be reused.
  assign flush_hist = (q_q == Q_FULL) && (OVERLAP == OVERLAP_OFF);

  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_win
      if (gi == 0) begin : g_new
        assign win_sym[0 +: W] = X;
        assign win_vld[0]      = 1'b1;
      end else begin : g_old
        assign win_sym[gi*W +: W] = hist_sym_q[gi-1];
        assign win_vld[gi]        = hist_vld_q[gi-1] && !flush_hist;
      end
      assign pat_flat[gi*W +: W] = pat_q[gi];

      moore_prefix_cmp #(.W(W), .K(gi + 1)) u_cmp (
        .win_sym (win_sym[(gi+1)*W-1:0]),
        .win_vld (win_vld[gi:0]),
        .pat_sym (pat_flat[(gi+1)*W-1:0]),
        .hit     (hit[gi])
      );
    end
  endgenerate

  // Priority encode: the longest matching prefix wins.
  always_comb begin
    q_scan = '0;
    for (int k = 0; k < LEN; k++) begin
      if (hit[k]) q_scan = QW'(k + 1);
    end
  end

  // Next-state logic: LOAD flushes and writes the pattern, otherwise EN consumes X.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    for (int i = 0; i < LEN; i++) begin
      hist_sym_d[i] = hist_sym_q[i];
      hist_vld_d[i] = hist_vld_q[i];
      pat_d[i]      = pat_q[i];
    end
    if (LOAD) begin
      q_d = '0;
      for (int i = 0; i < LEN; i++) begin
        hist_vld_d[i] = 1'b0;
        if (PAT_IDX == IW'(i)) pat_d[i] = PAT_DATA;
      end
    end else if (EN) begin
      q_d = q_scan;
      for (int i = 0; i < LEN; i++) begin
        hist_sym_d[i] = win_sym[i*W +: W];
        hist_vld_d[i] = win_vld[i];
      end
      if ((q_scan == Q_FULL) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
    if (CLR) cnt_d = '0;
  end

  // State, history, pattern and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LEN; i++) begin
        hist_sym_q[i] <= '0;
        hist_vld_q[i] <= 1'b0;
        pat_q[i]      <= '0;
      end
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LEN; i++) begin
        hist_sym_q[i] <= hist_sym_d[i];
        hist_vld_q[i] <= hist_vld_d[i];
        pat_q[i]      <= pat_d[i];
      end
    end
  end

  assign Q         = q_q;
  assign Z         = (q_q == Q_FULL);
  assign MATCH_CNT = cnt_q;
  assign CNT_SAT   = &cnt_q;

endmodule

// File: tb/tb_moore_pattern_det.sv
// Bench for moore_pattern_det with W=2, LEN=3, CNT_W=2: directed vector table,
// hand-written reset/back-to-back sequence, then random stimulus vs a model.
module tb_moore_pattern_det;

  logic       CLK = 1'b0;
  logic       RST, EN, OVERLAP, LOAD, CLR;
  logic [1:0] X, PAT_IDX, PAT_DATA;
  logic       Z;
  logic [1:0] Q;
  logic [1:0] MATCH_CNT;
  logic       CNT_SAT;

  always #5 CLK = ~CLK;

  moore_pattern_det #(.W(2), .LEN(3), .CNT_W(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .X         (X),
    .OVERLAP   (OVERLAP),
    .LOAD      (LOAD),
    .PAT_IDX   (PAT_IDX),
    .PAT_DATA  (PAT_DATA),
    .CLR       (CLR),
    .Z         (Z),
    .Q         (Q),
    .MATCH_CNT (MATCH_CNT),
    .CNT_SAT   (CNT_SAT)
  );

  typedef struct {
    logic       en, load, clr, ovl;
    logic [1:0] x, idx, data;
    int         eq;
    bit         ez;
    int         ecnt;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pattern, raw stream since the last flush, state, count.
  int m_pat[3];
  int m_hist[$];
  int m_q;
  int m_cnt;

  function automatic vec_t mk(logic en, logic load, logic clr, logic ovl,
                              logic [1:0] x, logic [1:0] idx, logic [1:0] data,
                              int eq, bit ez, int ecnt);
    vec_t v;
    v.en = en; v.load = load; v.clr = clr; v.ovl = ovl;
    v.x = x; v.idx = idx; v.data = data;
    v.eq = eq; v.ez = ez; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic en, input logic load,
                            input logic clr, input logic ovl, input logic [1:0] x,
                            input logic [1:0] idx, input logic [1:0] data);
    int nq;
    int sz;
    bit ok;
    if (rst) begin
      m_q = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_pat[i] = 0;
      m_hist.delete();
      return;
    end
    if (load) begin
      if (int'(idx) < 3) m_pat[idx] = int'(data);
      m_hist.delete();
      m_q = 0;
    end else if (en) begin
      if (!ovl && m_q == 3) m_hist.delete();
      m_hist.push_back(int'(x));
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      sz = m_hist.size();
      nq = 0;
      for (int k = 1; k <= sz; k++) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (m_hist[sz - k + j] != m_pat[j]) ok = 1'b0;
        if (ok) nq = k;
      end
      m_q = nq;
      if (m_q == 3 && m_cnt < 3) m_cnt = m_cnt + 1;
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic en, input logic load,
                      input logic clr, input logic ovl, input logic [1:0] x,
                      input logic [1:0] idx, input logic [1:0] data);
    RST = rst; EN = en; LOAD = load; CLR = clr; OVERLAP = ovl;
    X = x; PAT_IDX = idx; PAT_DATA = data;
    model_step(rst, en, load, clr, ovl, x, idx, data);
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int eq, input bit ez, input int ecnt);
    logic [5:0] got, exp;
    got = {Q, Z, MATCH_CNT, CNT_SAT};
    exp = {2'(eq), ez, 2'(ecnt), (ecnt == 3)};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got Q=%0d Z=%0d CNT=%0d SAT=%0d, required Q=%0d Z=%0d CNT=%0d SAT=%0d",
               name, Q, Z, MATCH_CNT, CNT_SAT, eq, ez, ecnt, (ecnt == 3));
    end
  endtask

  initial begin
    // en load clr ovl x idx data -> Q Z CNT
    vecs.push_back(mk(0,1,0,1, 0,0,1, 0,0,0));  // PAT = 1,2,1
    vecs.push_back(mk(0,1,0,1, 0,1,2, 0,0,0));
    vecs.push_back(mk(0,1,0,1, 0,2,1, 0,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,0));  // overlap stream 1,2,1,2,1
    vecs.push_back(mk(1,0,0,1, 2,0,0, 2,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 3,1,1));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 2,0,1));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 3,1,2));
    vecs.push_back(mk(0,0,1,1, 0,0,0, 3,1,0));  // CLR alone, state held
    vecs.push_back(mk(0,1,0,0, 0,2,1, 0,0,0));  // flush via LOAD
    vecs.push_back(mk(1,0,0,0, 1,0,0, 1,0,0));  // non-overlap stream 1,2,1,2,1
    vecs.push_back(mk(1,0,0,0, 2,0,0, 2,0,0));
    vecs.push_back(mk(1,0,0,0, 1,0,0, 3,1,1));
    vecs.push_back(mk(1,0,0,0, 2,0,0, 0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,0, 1,0,1));
    vecs.push_back(mk(0,1,0,0, 0,1,1, 0,0,1));  // PAT = 1,1,2
    vecs.push_back(mk(0,1,0,0, 0,2,2, 0,0,1));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,1));  // fallback stream 1,1,1,2
    vecs.push_back(mk(1,0,0,1, 1,0,0, 2,0,1));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 2,0,1));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 3,1,2));
    vecs.push_back(mk(0,0,0,1, 1,0,0, 3,1,2));  // hold with Z high
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,2));
    for (int i = 0; i < 5; i++)                 // EN=0 mid-pattern, X ignored
      vecs.push_back(mk(0,0,0,1, 2'(i),0,0, 1,0,2));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 2,0,2));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 3,1,3));  // counter saturates
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,3));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 2,0,3));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 3,1,3));  // held at all ones
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,3));
    vecs.push_back(mk(1,0,0,1, 1,0,0, 2,0,3));
    vecs.push_back(mk(1,0,1,1, 2,0,0, 3,1,0));  // CLR beats increment
    vecs.push_back(mk(0,1,0,1, 0,1,2, 0,0,0));  // PAT = 1,2,2
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,0));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 2,0,0));
    vecs.push_back(mk(1,1,0,1, 1,2,3, 0,0,0));  // LOAD beats EN, PAT = 1,2,3
    vecs.push_back(mk(1,0,0,1, 1,0,0, 1,0,0));
    vecs.push_back(mk(1,0,0,1, 2,0,0, 2,0,0));
    vecs.push_back(mk(1,0,0,1, 3,0,0, 3,1,1));

    step(1, 0,0,0,0, 0,0,0);
    step(1, 0,0,0,0, 0,0,0);
    check("reset", 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(0, vecs[i].en, vecs[i].load, vecs[i].clr, vecs[i].ovl,
           vecs[i].x, vecs[i].idx, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ez, vecs[i].ecnt);
    end

    // RST with Z high (and EN asserted) restores everything, pattern included.
    step(1, 1,0,0,1, 1,0,0);
    check("rst_mid", 0, 0, 0);
    step(0, 1,0,0,1, 0,0,0);
    check("zero_pat1", 1, 0, 0);
    step(0, 1,0,0,1, 0,0,0);
    check("zero_pat2", 2, 0, 0);
    step(0, 1,0,0,1, 0,0,0);
    check("zero_pat3", 3, 1, 1);
    step(0, 1,0,0,1, 0,0,0);
    check("back2back1", 3, 1, 2);
    step(0, 1,0,0,1, 0,0,0);
    check("back2back2", 3, 1, 3);

    // Random traffic against the model; small alphabet keeps matches frequent.
    begin
      logic ovl;
      logic en, load, clr;
      logic [1:0] x, idx, data;
      ovl = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 9) == 0) ovl = ~ovl;
        en   = ($urandom_range(0, 3) != 0);
        load = ($urandom_range(0, 24) == 0);
        clr  = ($urandom_range(0, 39) == 0);
        x    = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        idx  = 2'($urandom_range(0, 3));
        data = ($urandom_range(0, 4) != 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        step(($urandom_range(0, 499) == 0), en, load, clr, ovl, x, idx, data);
        check($sformatf("rand%0d", n), m_q, (m_q == 3), m_cnt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
